// File: rtl/matmul_pkg.sv
// Shared types and constants for the vertex transform sequencer and its testbench.
package matmul_pkg;

    typedef logic [15:0] fp16_t;
    typedef fp16_t [3:0] vec4_t;
    typedef fp16_t [15:0] mat4_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

    localparam fp16_t FP16_ONE = 16'h3C00;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; no bypass, data is visible the cycle after push.
module sync_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;

    assign pop_ok   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop_ok)      count <= count + CW'(1);
            else if (!push && pop_ok) count <= count - CW'(1);
        end
    end

    push_fits: assert property (@(posedge clk) disable iff (!rst)
        push |-> (count != CW'(DEPTH)) || pop_ok);

endmodule

// File: rtl/matmul_vertex_sched.sv
// Feeds vertices into the fixed-latency matmul datapath and queues its results,
// using in-flight credits so a result always finds room in the output FIFO.
module matmul_vertex_sched
    import matmul_pkg::*;
#(
    parameter int unsigned MM_LATENCY = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mat_wr_en,
    input  logic [3:0]   mat_wr_addr,
    input  logic [15:0]  mat_wr_data,
    input  logic         vin_valid,
    output logic         vin_ready,
    input  logic [63:0]  vin_data,
    input  logic         vin_last,
    output logic [255:0] mm_a,
    output logic [63:0]  mm_b,
    input  logic [63:0]  mm_x,
    output logic         vout_valid,
    input  logic         vout_ready,
    output logic [63:0]  vout_data,
    output logic         vout_last,
    output logic         busy,
    output logic         done,
    output logic         err
);

    sched_state_t      state;
    mat4_t             mat;
    logic [MM_LATENCY:0] tag_v;
    logic [MM_LATENCY:0] tag_l;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  inflight_nxt;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_nxt;
    logic [CNT_W:0]    credit_used;
    logic              hs;
    logic              push;
    logic              pop;

    assign mm_a        = mat;
    assign busy        = (state != IDLE);
    assign hs          = vin_valid && vin_ready;
    assign push        = tag_v[MM_LATENCY];
    assign vout_valid  = (fifo_count != '0);
    assign pop         = vout_valid && vout_ready;
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign vin_ready   = (state == RUN) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        inflight_nxt = inflight;
        if (hs && !push)      inflight_nxt = inflight + CNT_W'(1);
        else if (!hs && push) inflight_nxt = inflight - CNT_W'(1);
        count_nxt = fifo_count;
        if (push && !pop)      count_nxt = fifo_count + CNT_W'(1);
        else if (!push && pop) count_nxt = fifo_count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mat   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mat_wr_en) mat[mat_wr_addr] <= mat_wr_data;
                    if (start)     state <= RUN;
                end
                RUN: begin
                    if (mat_wr_en)     err   <= 1'b1;
                    if (hs && vin_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (mat_wr_en) err <= 1'b1;
                    // Look at next-cycle occupancy so done follows the final pop directly.
                    if (inflight_nxt == '0 && count_nxt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mm_b     <= '0;
            tag_v    <= '0;
            tag_l    <= '0;
            inflight <= '0;
        end else begin
            if (hs) mm_b <= vin_data;
            tag_v    <= {tag_v[MM_LATENCY-1:0], hs};
            tag_l    <= {tag_l[MM_LATENCY-1:0], hs && vin_last};
            inflight <= inflight_nxt;
        end
    end

    sync_fifo #(
        .WIDTH (65),
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({tag_l[MM_LATENCY], mm_x}),
        .pop       (pop),
        .pop_data  ({vout_last, vout_data}),
        .count     (fifo_count)
    );

endmodule

// File: doc/matmul_vertex_sched.md
Name: matmul_vertex_sched

Overview:
Sequencer wrapped around the 4x4 fp16 matmul datapath. It holds the 16-word transform matrix, streams 4-component fp16 vertices into the datapath and tracks each one through the fixed-latency, non-stallable pipeline. Results are captured in an output FIFO so that downstream backpressure never drops a result. It sits between the vertex fetch stage and the clip/raster stage.

Parameters:
MM_LATENCY, 4, clocks from a valid mm_b to the matching valid mm_x; must equal the datapath's total latency
FIFO_DEPTH, 8, output FIFO entries, power of two, >= 2; also the in-flight credit limit
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a run from IDLE
mat_wr_en  in  1  matrix word write strobe
mat_wr_addr  in  4  word index: row*4+col
mat_wr_data  in  16  fp16 matrix word
vin_valid  in  1  vertex valid
vin_ready  out  1  vertex accept
vin_data  in  64  vertex, packed [3:0][15:0]
vin_last  in  1  marks the final vertex of the run
mm_a  out  256  matrix to the datapath, packed [15:0][15:0]
mm_b  out  64  vertex to the datapath
mm_x  in  64  datapath result
vout_valid  out  1  result valid
vout_ready  in  1  downstream accept
vout_data  out  64  transformed vertex
vout_last  out  1  result of the last vertex
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at the end of a run
err  out  1  sticky; set by a matrix write outside IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs, the matrix and mm_b go to 0.
  - State goes to IDLE; the FIFO and the valid/last shift register are emptied; err is cleared.
  - Reset mid-run discards all in-flight and queued results; no done pulse follows.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: mat_wr_en writes mat_wr_data into word mat_wr_addr, and mm_a shows it the next cycle. start moves to RUN. If start and mat_wr_en arrive in the same cycle, the write is still performed.
  - RUN: vin_ready = (inflight + fifo_count < FIFO_DEPTH). A handshake with vin_last=1 moves to DRAIN.
  - DRAIN: vin_ready = 0. When inflight = 0, fifo_count = 0 and no pop is pending, pulse done for one cycle and return to IDLE.
- Matrix writes in RUN or DRAIN are ignored and set err. err clears only on reset.
- Issue path:
  - On a vin handshake at cycle T, mm_b <= vin_data. mm_b is valid in cycle T+1.
  - A (valid, last) tag enters a shift register of length MM_LATENCY+1.
  - The tag exits at T+1+MM_LATENCY. In that cycle mm_x is written into the FIFO together with the last bit.
  - mm_b holds its last value when there is no handshake.
- Credit counter inflight:
  - +1 on a handshake, -1 when a tag exits; both in the same cycle leaves it unchanged.
  - Because of the credit rule, a FIFO push always finds space; a push into a full FIFO is an assertion failure.
- FIFO:
  - vout_valid = (fifo_count != 0); vout_data and vout_last come from the head entry.
  - Pop happens on vout_valid & vout_ready.
  - Simultaneous push and pop leaves the count unchanged, including when the FIFO is full or empty-with-push. An empty FIFO never bypasses the push; data appears the cycle after the push.
  - Pointers wrap modulo FIFO_DEPTH.
- Minimum latency: vin handshake at T gives vout_valid at T+2+MM_LATENCY (6 cycles at the default).
- The datapath output is passed through unmodified. Component 3 is produced by the datapath, not by this block.

Decomposition:
- Shared package matmul_pkg holds:
  - typedefs fp16_t (logic[15:0]), vec4_t (fp16_t[3:0]) and mat4_t (fp16_t[15:0]);
  - FSM enum sched_state_t {IDLE, RUN, DRAIN};
  - constant FP16_ONE = 16'h3C00.
- One sub-module: sync_fifo (parameterised WIDTH=65, DEPTH). Its push/pop/count interface is reused elsewhere.

Test Plan:
- Reset, then write the identity matrix (words 0, 5, 10, 15 = 16'h3C00, all others 0), pulse start, and stream {1.0, 2.0, 3.0, last} with vout_ready=1:
  - outputs equal the inputs in order;
  - first vout_valid is 6 cycles after the first handshake;
  - done pulses once; busy returns to 0.
- Hold vout_ready=0 and offer 12 vertices:
  - exactly 8 are accepted, then vin_ready=0;
  - release vout_ready: all 12 emerge in order with no loss;
  - FIFO count never exceeds 8.
- Full FIFO with a tag exiting and vout_ready=1 in the same cycle: count stays at 8 and data order is preserved.
- mat_wr_en during RUN: the matrix is unchanged, err=1 and stays 1 after the run; start in the same cycle as a write from IDLE: the write is applied.
- Assert rst low in DRAIN with 3 vertices queued:
  - all outputs go to 0 immediately;
  - no done pulse;
  - the next run behaves exactly as after a fresh reset.
- vin_last on the first vertex with vout_ready toggling 1010...: a single output with vout_last=1, then done exactly one cycle after its pop.
